// File: rtl/sha256_core_if.sv
// Request/result bundle for sha256_core: one 512-bit block in, one 256-bit digest out.
interface sha256_core_if;
    logic         start;
    logic         first;
    logic [511:0] block;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    modport master (output start, first, block, input busy, done, digest);
    modport slave  (input start, first, block, output busy, done, digest);
endinterface

// File: rtl/sha256_core.sv
// SHA-256 compression engine: one pre-padded block per start, ROUNDS_PER_CYCLE rounds per clock,
// chaining value H kept internally so multi-block messages need no external state.
module sha256_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned DONE_HOLD        = 0
) (
    input logic        clock,
    input logic        reset,
    sha256_core_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t        state, state_n;
    logic [5:0]    rnd;
    logic [31:0]   hreg [8];
    logic [31:0]   v    [8];
    logic [31:0]   w    [16];
    logic [31:0]   vn   [8];
    logic [31:0]   wn   [16];
    logic [31:0]   hsum [8];
    logic [31:0]   t1, t2, ws;
    logic [255:0]  digest_r;
    logic          done_r;
    logic          accept;

    assign accept     = (state == IDLE) && bus.start;
    assign bus.done   = done_r;
    assign bus.digest = digest_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        bus.busy = (state != IDLE);
        case (state)
            IDLE:    if (bus.start) state_n = ROUND;
            ROUND:   if (rnd == LAST_RND) state_n = FINAL;
            FINAL:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Rounds are chained combinationally; w[0] is always W_t for the round being applied.
    always_comb begin
        vn = v;
        wn = w;
        t1 = '0;
        t2 = '0;
        ws = '0;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            t1 = vn[7] + bsig1(vn[4]) + ((vn[4] & vn[5]) ^ (~vn[4] & vn[6]))
               + K[rnd + 6'(j)] + wn[0];
            t2 = bsig0(vn[0]) + ((vn[0] & vn[1]) ^ (vn[0] & vn[2]) ^ (vn[1] & vn[2]));
            vn[7] = vn[6];
            vn[6] = vn[5];
            vn[5] = vn[4];
            vn[4] = vn[3] + t1;
            vn[3] = vn[2];
            vn[2] = vn[1];
            vn[1] = vn[0];
            vn[0] = t1 + t2;
            ws = ssig1(wn[14]) + wn[9] + ssig0(wn[1]) + wn[0];
            for (int unsigned k = 0; k < 15; k++) begin
                wn[k] = wn[k + 1];
            end
            wn[15] = ws;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            hsum[i] = hreg[i] + v[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                hreg[i] <= IV[i];
                v[i]    <= '0;
            end
            for (int unsigned i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
            rnd      <= '0;
            done_r   <= 1'b0;
            digest_r <= '0;
        end else begin
            if (DONE_HOLD == 0 || accept) begin
                done_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            w[i] <= bus.block[511 - 32*i -: 32];
                        end
                        for (int unsigned i = 0; i < 8; i++) begin
                            v[i] <= bus.first ? IV[i] : hreg[i];
                            if (bus.first) hreg[i] <= IV[i];
                        end
                        rnd <= '0;
                    end
                end
                ROUND: begin
                    v   <= vn;
                    w   <= wn;
                    rnd <= rnd + 6'(ROUNDS_PER_CYCLE);
                end
                FINAL: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        hreg[i]                  <= hsum[i];
                        digest_r[255 - 32*i -: 32] <= hsum[i];
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core.sv
// Directed known-answer bench for sha256_core across rounds-per-cycle and done-hold variants.
module tb_sha256_core;

    localparam logic [511:0] BLK_ABC =
        512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
    localparam logic [511:0] BLK_HELLO =
        512'h68656c6c_6f20776f_726c6480_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000058;
    localparam logic [511:0] BLK_EMPTY =
        512'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
    localparam logic [511:0] BLK_448A =
        512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] BLK_448B =
        512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;

    localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_HELLO = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
    localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_s [5];
    logic         first_s = 1'b0;
    logic [511:0] block_s = '0;
    logic [4:0]   busy_s;
    logic [4:0]   done_s;
    logic [255:0] digest_s [5];

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    sha256_core_if bus0 ();
    sha256_core_if bus1 ();
    sha256_core_if bus2 ();
    sha256_core_if bus3 ();
    sha256_core_if bus4 ();

    assign bus0.start = start_s[0]; assign bus0.first = first_s; assign bus0.block = block_s;
    assign bus1.start = start_s[1]; assign bus1.first = first_s; assign bus1.block = block_s;
    assign bus2.start = start_s[2]; assign bus2.first = first_s; assign bus2.block = block_s;
    assign bus3.start = start_s[3]; assign bus3.first = first_s; assign bus3.block = block_s;
    assign bus4.start = start_s[4]; assign bus4.first = first_s; assign bus4.block = block_s;

    assign busy_s[0] = bus0.busy; assign done_s[0] = bus0.done; assign digest_s[0] = bus0.digest;
    assign busy_s[1] = bus1.busy; assign done_s[1] = bus1.done; assign digest_s[1] = bus1.digest;
    assign busy_s[2] = bus2.busy; assign done_s[2] = bus2.done; assign digest_s[2] = bus2.digest;
    assign busy_s[3] = bus3.busy; assign done_s[3] = bus3.done; assign digest_s[3] = bus3.digest;
    assign busy_s[4] = bus4.busy; assign done_s[4] = bus4.done; assign digest_s[4] = bus4.digest;

    sha256_core #(.ROUNDS_PER_CYCLE(1), .DONE_HOLD(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    sha256_core #(.ROUNDS_PER_CYCLE(2), .DONE_HOLD(0)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    sha256_core #(.ROUNDS_PER_CYCLE(4), .DONE_HOLD(0)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
    sha256_core #(.ROUNDS_PER_CYCLE(8), .DONE_HOLD(0)) dut3 (.clock(clock), .reset(reset), .bus(bus3));
    sha256_core #(.ROUNDS_PER_CYCLE(1), .DONE_HOLD(1)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accept edge.
    task automatic pulse_start(input int idx, input logic f, input logic [511:0] b);
        first_s      = f;
        block_s      = b;
        start_s[idx] = 1'b1;
        @(negedge clock);
        start_s[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int cyc);
        cyc = 0;
        while (!done_s[idx] && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_block(input string tag, input int idx, input logic f,
                             input logic [511:0] b, input logic [255:0] exp, input int lat);
        int cyc;
        pulse_start(idx, f, b);
        check({tag, "_busy"}, 256'(busy_s[idx]), 256'(1));
        wait_done(idx, cyc);
        check({tag, "_lat"}, 256'(cyc), 256'(lat));
        check({tag, "_dig"}, digest_s[idx], exp);
    endtask

    initial begin
        int cyc;
        int ndone;
        for (int i = 0; i < 5; i++) start_s[i] = 1'b0;

        // Reset state, with start held high during reset.
        start_s[0] = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy", 256'(busy_s[0]), 256'(0));
        check("rst_done", 256'(done_s[0]), 256'(0));
        check("rst_dig", digest_s[0], 256'(0));
        start_s[0] = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_start_ign", 256'(busy_s[0]), 256'(0));

        run_block("abc", 0, 1'b1, BLK_ABC, DG_ABC, 65);
        @(negedge clock);
        check("abc_pulse", 256'(done_s[0]), 256'(0));
        repeat (3) @(negedge clock);
        check("abc_stable", digest_s[0], DG_ABC);

        run_block("hello", 0, 1'b1, BLK_HELLO, DG_HELLO, 65);
        @(negedge clock);
        run_block("empty", 0, 1'b1, BLK_EMPTY, DG_EMPTY, 65);
        @(negedge clock);

        // Two-block message, second block issued in the first block's done cycle.
        pulse_start(0, 1'b1, BLK_448A);
        wait_done(0, cyc);
        check("b448a_lat", 256'(cyc), 256'(65));
        run_block("b448b", 0, 1'b0, BLK_448B, DG_448, 65);
        @(negedge clock);

        // Restart attempt mid-ROUND and block/first changed after accept.
        pulse_start(0, 1'b1, BLK_ABC);
        repeat (9) @(negedge clock);
        pulse_start(0, 1'b0, BLK_EMPTY);
        block_s = BLK_HELLO;
        first_s = 1'b1;
        wait_done(0, cyc);
        check("ign_lat", 256'(cyc + 10), 256'(65));
        check("ign_dig", digest_s[0], DG_ABC);
        @(negedge clock);

        // Reset around round 30 abandons the block.
        pulse_start(0, 1'b1, BLK_HELLO);
        repeat (30) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 256'(busy_s[0]), 256'(0));
        check("midrst_dig", digest_s[0], 256'(0));
        check("midrst_done", 256'(done_s[0]), 256'(0));
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            if (done_s[0]) ndone++;
        end
        check("midrst_nodone", 256'(ndone), 256'(0));
        check("midrst_dig2", digest_s[0], 256'(0));

        run_block("abc_f0", 0, 1'b0, BLK_ABC, DG_ABC, 65);
        @(negedge clock);

        run_block("rpc2", 1, 1'b1, BLK_ABC, DG_ABC, 33);
        @(negedge clock);
        run_block("rpc4", 2, 1'b1, BLK_ABC, DG_ABC, 17);
        @(negedge clock);
        run_block("rpc8", 3, 1'b1, BLK_ABC, DG_ABC, 9);
        @(negedge clock);

        // Held done clears only on the next accepted start.
        run_block("hold", 4, 1'b1, BLK_ABC, DG_ABC, 65);
        repeat (5) @(negedge clock);
        check("hold_high", 256'(done_s[4]), 256'(1));
        pulse_start(4, 1'b1, BLK_HELLO);
        check("hold_clr", 256'(done_s[4]), 256'(0));
        wait_done(4, cyc);
        check("hold2_lat", 256'(cyc), 256'(65));
        check("hold2_dig", digest_s[4], DG_HELLO);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, meaning SHA-256 rounds evaluated per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter DONE_HOLD, default 0, meaning 0 = done is a one-cycle pulse, 1 = done holds until the next accepted start.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to compress one 512-bit block.
REQ-006 SHALL have port first  input  1  sampled with start; 1 = chain from the FIPS 180-4 IV, 0 = chain from the current internal H.
REQ-007 SHALL have port block  input  512  pre-padded message block; bits [511:480] = W0, big-endian words.
REQ-008 SHALL have port busy  output  1  high while a block is being compressed.
REQ-009 SHALL have port done  output  1  digest valid indication, per DONE_HOLD.
REQ-010 SHALL have port digest  output  256  H0..H7 concatenated, with H0 in bits [255:224].

Function
REQ-011 SHALL implement states IDLE, ROUND and FINAL; busy = 1 in ROUND and FINAL only.
REQ-012 SHALL accept start only in IDLE; start in ROUND or FINAL SHALL be ignored, with no queuing and no effect on the current block.
REQ-013 On an accepted start edge, SHALL perform all of the following:
- latch block into a 16-word W window;
- load a..h from the IV if first = 1, else from H;
- when first = 1, also load H from the IV;
- clear the round counter to 0;
- enter ROUND.
REQ-014 Each ROUND edge SHALL apply ROUNDS_PER_CYCLE chained rounds (K constants in round order) and advance the W window by the same count using the sigma0/sigma1 schedule.
REQ-015 After 64/ROUNDS_PER_CYCLE ROUND edges, SHALL enter FINAL.
REQ-016 The FINAL edge SHALL:
- set H[i] = H[i] + working var[i], modulo 2^32 per word;
- drive digest = updated H;
- assert done;
- return to IDLE.
REQ-017 Latency from the start-accept edge to done high SHALL be exactly 64/ROUNDS_PER_CYCLE + 1 clocks (65 clocks at the default).
REQ-018 All additions SHALL be 32-bit modulo 2^32, with carries discarded.
REQ-019 digest SHALL change only on a FINAL edge and SHALL be stable at all other times.
REQ-020 With DONE_HOLD = 0, done SHALL be high for exactly one cycle.
REQ-021 With DONE_HOLD = 1, done SHALL stay high until the next accepted start edge, where it clears.
REQ-022 start asserted in the cycle done is high SHALL be accepted, giving back-to-back blocks with zero idle cycles between them.
REQ-023 A multi-block message SHALL be hashed by issuing its first block with first = 1 and each later block with first = 0; H carries between blocks.
REQ-024 first sampled while not in IDLE SHALL have no effect.
REQ-025 block SHALL be sampled only on the accept edge; later changes to block SHALL not affect the result.

Reset
REQ-026 Asserting reset SHALL immediately force all of the following:
- state = IDLE;
- busy = 0;
- done = 0;
- digest = 0;
- H = IV;
- round counter = 0.
REQ-027 Reset asserted mid-operation SHALL abandon the block, with no done and no digest update.
REQ-028 The first start after reset, with first = 0, SHALL chain from the IV.
REQ-029 start asserted while reset is high SHALL be ignored.

Verification
REQ-030 SHALL cover "abc" (one padded block, first = 1) -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with done 65 clocks after start at the default.
REQ-031 SHALL cover "hello world" (length 88 bits, padded, first = 1) -> digest b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9.
REQ-032 SHALL cover the empty message (0x80 followed by zeros, length 0) -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-033 SHALL cover the 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as two blocks, with block 2 started in block 1's done cycle with first = 0:
- result -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
- no gap cycle between the blocks.
REQ-034 SHALL cover start pulsed mid-ROUND, and block changed after accept -> "abc" digest unchanged and latency unchanged.
REQ-035 SHALL cover reset pulsed at round 30 -> busy = 0, digest = 0, no done.
REQ-036 SHALL cover, after REQ-035, "abc" with first = 0 -> "abc" digest.
REQ-037 SHALL repeat REQ-030 for ROUNDS_PER_CYCLE = 1, 2, 4, 8 -> identical digest, with done at 65/33/17/9 clocks.
REQ-038 SHALL repeat REQ-030 with DONE_HOLD = 1 -> done stays high until the next start.
